// File: rtl/serial_det_scheduler_pkg.sv
// ============================================================================
// Module   : serial_det_scheduler_pkg
// Brief    : Shared types, default sizes and round-robin search helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_det_scheduler_pkg;

   localparam int DEF_NREQ  = 4;
   localparam int DEF_WIDTH = 8;
   localparam int MAX_NREQ  = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   // Returns the first set request after 'last', wrapping; -1 when none.
   function automatic int rr_next(input logic [MAX_NREQ-1:0] req, input int nreq, input int last);
      int idx;
      rr_next = -1;
      for (int k = nreq; k >= 1; k--) begin
         idx = (last + k) % nreq;
         if (req[idx[4:0]]) rr_next = idx;
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_det_scheduler_if.sv
// ============================================================================
// Module   : serial_det_scheduler_if
// Brief    : Requester/scheduler bundle with producer and scheduler modports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_det_scheduler_if
   import serial_det_scheduler_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(WIDTH + 1);

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] data;
   logic [NREQ-1:0]       grant;
   logic                  busy;
   logic                  done;
   logic [IDW-1:0]        done_id;
   logic [CW-1:0]         hit_count;
   logic                  hit_any;

   modport master (
      output req, data,
      input  grant, busy, done, done_id, hit_count, hit_any
   );

   modport slave (
      input  req, data,
      output grant, busy, done, done_id, hit_count, hit_any
   );

endinterface

`default_nettype wire

// File: rtl/serial_det_scheduler_det.sv
// ============================================================================
// Module   : ones_window_det
// Brief    : Bit-serial "two or more ones in a 3-bit window" detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ones_window_det (
   input  wire logic clk,
   input  wire logic reset,
   input  wire logic clr,
   input  wire logic en,
   input  wire logic din,
   output logic      hit
);

   logic [1:0] h_q;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         h_q <= 2'b00;
      end else if (en) begin
         h_q <= {h_q[0], din};
      end
   end

   assign hit = (h_q[1] & h_q[0]) | (din & (h_q[1] | h_q[0]));

endmodule

`default_nettype wire

// File: rtl/serial_det_scheduler.sv
// ============================================================================
// Module   : serial_det_scheduler
// Brief    : Round-robin arbiter sharing one serial window detector among NREQ words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_det_scheduler
   import serial_det_scheduler_pkg::*;
#(
   parameter int NREQ  = DEF_NREQ,
   parameter int WIDTH = DEF_WIDTH
) (
   input  wire logic             clk,
   input  wire logic             reset,
   serial_det_scheduler_if.slave bus
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  C_SAT      = CW'(WIDTH);
   localparam logic [CW-1:0]  C_LAST_BIT = CW'(WIDTH - 1);
   localparam logic [IDW-1:0] C_LAST_RST = IDW'(NREQ - 1);

   state_t             state_q, state_d;
   logic [IDW-1:0]     last_q, last_d;
   logic [IDW-1:0]     id_q, id_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [CW-1:0]      bit_q, bit_d;
   logic [CW-1:0]      hits_q, hits_d;
   logic [IDW-1:0]     done_id_q, done_id_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               any_q, any_d;

   logic [MAX_NREQ-1:0] w_req_ext;
   int                  w_pick;
   logic [IDW-1:0]      w_idx;
   logic [NREQ-1:0]     w_grant;
   logic                w_clr;
   logic                w_en;
   logic                w_done;
   logic                w_hit;

   ones_window_det u_det (
      .clk   (clk),
      .reset (reset),
      .clr   (w_clr),
      .en    (w_en),
      .din   (shift_q[0]),
      .hit   (w_hit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         last_q    <= C_LAST_RST;
         id_q      <= '0;
         shift_q   <= '0;
         bit_q     <= '0;
         hits_q    <= '0;
         done_id_q <= '0;
         cnt_q     <= '0;
         any_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         id_q      <= id_d;
         shift_q   <= shift_d;
         bit_q     <= bit_d;
         hits_q    <= hits_d;
         done_id_q <= done_id_d;
         cnt_q     <= cnt_d;
         any_q     <= any_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      id_d      = id_q;
      shift_d   = shift_q;
      bit_d     = bit_q;
      hits_d    = hits_q;
      done_id_d = done_id_q;
      cnt_d     = cnt_q;
      any_d     = any_q;
      w_grant   = '0;
      w_clr     = 1'b0;
      w_en      = 1'b0;
      w_done    = 1'b0;

      w_req_ext            = '0;
      w_req_ext[NREQ-1:0]  = bus.req;
      w_pick               = rr_next(w_req_ext, NREQ, int'(last_q));
      w_idx                = w_pick[IDW-1:0];

      case (state_q)
         ST_IDLE: begin
            if (w_pick >= 0) begin
               w_grant[w_idx] = 1'b1;
               w_clr          = 1'b1;
               last_d         = w_idx;
               id_d           = w_idx;
               shift_d        = bus.data[int'(w_idx)*WIDTH +: WIDTH];
               bit_d          = '0;
               hits_d         = '0;
               state_d        = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_en    = 1'b1;
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            if (w_hit && (hits_q != C_SAT)) hits_d = hits_q + 1'b1;
            // Results include the final bit's hit so they are valid during done.
            if (bit_q == C_LAST_BIT) begin
               state_d   = ST_REPORT;
               done_id_d = id_q;
               cnt_d     = hits_d;
               any_d     = (hits_d != '0);
            end
         end
         ST_REPORT: begin
            w_done  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.grant     = w_grant;
   assign bus.busy      = (state_q != ST_IDLE) | (|w_grant);
   assign bus.done      = w_done;
   assign bus.done_id   = done_id_q;
   assign bus.hit_count = cnt_q;
   assign bus.hit_any   = any_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_det_scheduler.sv
// ============================================================================
// Module   : tb_serial_det_scheduler
// Brief    : Cycle-level reference model bench for serial_det_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_det_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   serial_det_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   serial_det_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: phase 0 = idle, 1..WIDTH = shifting, WIDTH+1 = reporting.
   int              m_phase   = 0;
   int              m_last    = NREQ - 1;
   int              m_id      = 0;
   int              m_done_id = 0;
   int              m_hits    = 0;
   logic [WIDTH-1:0] m_word   = '0;
   bit              m_valid   = 1'b0;
   logic [NREQ-1:0] m_gnt     = '0;

   function automatic int window_hits(input logic [WIDTH-1:0] w);
      int n = 0;
      for (int i = 0; i < WIDTH; i++) begin
         int ones = int'(w[i]);
         if (i >= 1) ones += int'(w[i-1]);
         if (i >= 2) ones += int'(w[i-2]);
         if (ones >= 2) n++;
      end
      return n;
   endfunction

   function automatic int rr_ref(input logic [NREQ-1:0] rq, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (rq[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ*WIDTH-1:0] dt);
      int              pick;
      logic [NREQ-1:0] eg;
      logic            eb;
      logic            ed;
      @(posedge clk);
      #1;
      reset    = r;
      bus.req  = rq;
      bus.data = dt;
      @(negedge clk);
      pick = (m_phase == 0) ? rr_ref(rq, m_last) : -1;
      eg   = '0;
      if (pick >= 0) eg[pick] = 1'b1;
      eb   = (m_phase != 0) || (pick >= 0);
      ed   = (m_phase == WIDTH + 1);
      if (m_valid) begin
         chk("grant",     32'(bus.grant),     32'(eg));
         chk("busy",      32'(bus.busy),      32'(eb));
         chk("done",      32'(bus.done),      32'(ed));
         chk("done_id",   32'(bus.done_id),   32'(m_done_id));
         chk("hit_count", 32'(bus.hit_count), 32'(m_hits));
         chk("hit_any",   32'(bus.hit_any),   32'(m_hits != 0));
      end
      m_gnt = eg;
      if (r) begin
         m_phase = 0; m_last = NREQ - 1; m_done_id = 0; m_hits = 0; m_valid = 1'b1;
      end else if (pick >= 0) begin
         m_phase = 1; m_last = pick; m_id = pick; m_word = dt[pick*WIDTH +: WIDTH];
      end else if (m_phase == WIDTH) begin
         m_phase = WIDTH + 1; m_done_id = m_id; m_hits = window_hits(m_word);
      end else if (m_phase == WIDTH + 1) begin
         m_phase = 0;
      end else if (m_phase != 0) begin
         m_phase++;
      end
   endtask

   function automatic logic [NREQ*WIDTH-1:0] slot(input int i, input logic [WIDTH-1:0] w);
      logic [NREQ*WIDTH-1:0] d = '0;
      d[i*WIDTH +: WIDTH] = w;
      return d;
   endfunction

   task automatic single(input int i, input logic [WIDTH-1:0] w, input int exp_hits, input string tag);
      logic [NREQ-1:0] rq = '0;
      rq[i] = 1'b1;
      step(1'b0, rq, slot(i, w));
      chk({tag, "_grant"}, 32'(bus.grant), 32'(rq));
      repeat (WIDTH + 1) step(1'b0, '0, slot(i, ~w));
      chk({tag, "_done"},    32'(bus.done),      32'd1);
      chk({tag, "_id"},      32'(bus.done_id),   32'(i));
      chk({tag, "_hits"},    32'(bus.hit_count), 32'(exp_hits));
      chk({tag, "_any"},     32'(bus.hit_any),   32'(exp_hits != 0));
   endtask

   initial begin
      logic [NREQ-1:0]       rq;
      logic [NREQ*WIDTH-1:0] dt;
      bus.req  = '0;
      bus.data = '0;

      repeat (3) step(1'b1, '0, '0);
      chk("rst_busy",  32'(bus.busy),      32'd0);
      chk("rst_count", 32'(bus.hit_count), 32'd0);

      single(0, 8'h07, 3, "w07");
      single(2, 8'h55, 3, "w55");
      single(1, 8'hFF, 7, "wFF");
      single(3, 8'h00, 0, "w00");

      // All requesters held: grants rotate every word period.
      step(1'b1, '0, '0);
      for (int k = 0; k < 41; k++) begin
         step(1'b0, 4'b1111, 32'hA5C3_0F96);
         if (k % (WIDTH + 2) == 0) chk("rr_all", 32'(bus.grant), 32'(1 << ((k / (WIDTH + 2)) % NREQ)));
      end

      // Reset during bit 4 of the shift discards the word and restarts priority.
      step(1'b1, '0, '0);
      step(1'b0, 4'b0011, 32'h0000_00FF);
      repeat (4) step(1'b0, 4'b0011, 32'h0000_00FF);
      step(1'b1, 4'b0011, 32'h0000_00FF);
      step(1'b0, 4'b0011, 32'h0000_00FF);
      chk("rst_regrant", 32'(bus.grant),     32'b0001);
      chk("rst_done",    32'(bus.done),      32'd0);
      chk("rst_hits",    32'(bus.hit_count), 32'd0);
      repeat (WIDTH + 1) step(1'b0, '0, '0);

      // Late request from 1 wins over re-raised 0.
      step(1'b1, '0, '0);
      step(1'b0, 4'b0001, 32'h0000_0707);
      repeat (3) step(1'b0, 4'b0000, 32'h0000_0707);
      repeat (2) step(1'b0, 4'b0010, 32'h0000_0707);
      repeat (4) step(1'b0, 4'b0011, 32'h0000_0707);
      step(1'b0, 4'b0011, 32'h0000_0707);
      chk("rr_late1", 32'(bus.grant), 32'b0010);
      repeat (WIDTH + 1) step(1'b0, 4'b0001, 32'h0000_0707);
      step(1'b0, 4'b0001, 32'h0000_0707);
      chk("rr_then0", 32'(bus.grant), 32'b0001);

      // Random traffic: requests held until granted, occasional drops and resets.
      rq = '0;
      for (int c = 0; c < 500; c++) begin
         rq &= ~m_gnt;
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(3) == 0) rq[i] = 1'b1;
            else if ($urandom_range(15) == 0) rq[i] = 1'b0;
         end
         for (int i = 0; i < NREQ; i++) dt[i*WIDTH +: WIDTH] = WIDTH'($urandom());
         step(($urandom_range(99) == 0), rq, dt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
